write_control_logic: RTL and testbench

WRITE_CONTROL_LOGIC -- requirements
Module: write_control_logic

---
 rtl/write_control_logic.sv | 79 +++++++
 tb/tb_write_control_logic.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/write_control_logic.sv
// write_control_logic: write-side pointer, full/almost-full flags and
// overflow tracking for a single-clock FIFO. The read pointer comes in
// from the read-side control in the same clock domain.
//
// Optional feature: define WRITE_CTRL_OVF_COUNT_EN to add an 8-bit
// saturating count of dropped writes on port overflow_count.
module write_control_logic #(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL      = 3,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH:0]   read_ptr,
  output logic                  write_enable,
  output logic                  write_ack,
  output logic                  fifo_full,
  output logic                  fifo_afull,
  output logic [ADDR_WIDTH:0]   write_ptr,
  output logic                  overflow
`ifdef WRITE_CTRL_OVF_COUNT_EN
  ,
  output logic [7:0]            overflow_count
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  // Occupancy at or above this level raises fifo_afull.
  localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'(DEPTH - AFULL);

  logic [PTR_W-1:0] occupancy;
  logic             write_drop;

  // Full compares against the read pointer as presented this cycle, so a
  // read landing on the same edge does not make room for a write.
  assign fifo_full    = (write_ptr[ADDR_WIDTH] != read_ptr[ADDR_WIDTH]) &&
                        (write_ptr[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]);
  assign occupancy    = write_ptr - read_ptr;
  assign fifo_afull   = (occupancy >= AFULL_LEVEL);
  assign write_enable = write_req & ~fifo_full;
  assign write_drop   = write_req & fifo_full;

  // Write pointer, acknowledge and sticky overflow; flush beats any write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_ptr <= '0;
      write_ack <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      write_ptr <= '0;
      write_ack <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (write_enable) begin
        write_ptr <= write_ptr + PTR_W'(1);
      end
      write_ack <= write_enable;
      if (write_drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef WRITE_CTRL_OVF_COUNT_EN
  // Saturating count of dropped writes, cleared with the rest of the write side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_count <= 8'd0;
    end else if (flush) begin
      overflow_count <= 8'd0;
    end else if (write_drop && (overflow_count != 8'hFF)) begin
      overflow_count <= overflow_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_write_control_logic.sv
// Directed bench for write_control_logic (default parameters).
module tb_write_control_logic;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       write_req;
  logic [4:0] read_ptr;
  logic       write_enable;
  logic       write_ack;
  logic       fifo_full;
  logic       fifo_afull;
  logic [4:0] write_ptr;
  logic       overflow;
`ifdef WRITE_CTRL_OVF_COUNT_EN
  logic [7:0] overflow_count;
`endif

  int total = 0;
  int bad   = 0;

  write_control_logic #(.ADDR_WIDTH(4), .AFULL(3), .DEPTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .write_req    (write_req),
    .read_ptr     (read_ptr),
    .write_enable (write_enable),
    .write_ack    (write_ack),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .write_ptr    (write_ptr),
    .overflow     (overflow)
`ifdef WRITE_CTRL_OVF_COUNT_EN
    ,
    .overflow_count (overflow_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_writes(input int n);
    write_req = 1'b1;
    repeat (n) step();
    write_req = 1'b0;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    write_req = 1'b0;
    read_ptr  = 5'd0;
    #2;
    chk("rst_ptr",   write_ptr,  0);
    chk("rst_ack",   write_ack,  0);
    chk("rst_ovf",   overflow,   0);
    chk("rst_full",  fifo_full,  0);
    chk("rst_afull", fifo_afull, 0);
    chk("rst_we",    write_enable, 0);
`ifdef WRITE_CTRL_OVF_COUNT_EN
    chk("rst_cnt",   overflow_count, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Fill 16 entries from empty.
    write_req = 1'b1;
    #1;
    chk("fill_we0", write_enable, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("fill_ptr",   write_ptr,  k);
      chk("fill_ack",   write_ack,  1);
      chk("fill_afull", fifo_afull, (k >= 13) ? 1 : 0);
      chk("fill_full",  fifo_full,  (k == 16) ? 1 : 0);
    end
    chk("full_ptr", write_ptr, 5'b10000);
    chk("full_we",  write_enable, 0);

    // Three writes while full are dropped.
    step();
    chk("drop1_ptr", write_ptr, 16);
    chk("drop1_ack", write_ack, 0);
    chk("drop1_ovf", overflow,  1);
    step();
    step();
    write_req = 1'b0;
    chk("drop3_ptr", write_ptr, 16);
    chk("drop3_ack", write_ack, 0);
    chk("drop3_ovf", overflow,  1);
`ifdef WRITE_CTRL_OVF_COUNT_EN
    chk("drop3_cnt", overflow_count, 3);
`endif

    // Flush alone clears everything, then refill.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ptr", write_ptr, 0);
    chk("fl_ack", write_ack, 0);
    chk("fl_ovf", overflow,  0);
`ifdef WRITE_CTRL_OVF_COUNT_EN
    chk("fl_cnt", overflow_count, 0);
`endif
    do_writes(16);
    chk("refill_full", fifo_full, 1);
    chk("refill_ovf",  overflow,  0);

    // Write on the same edge as a read while full: dropped; retry accepted.
    write_req = 1'b1;
    step();
    read_ptr = 5'd1;
    #1;
    chk("samerd_ptr",  write_ptr, 16);
    chk("samerd_ack",  write_ack, 0);
    chk("samerd_ovf",  overflow,  1);
    chk("samerd_full", fifo_full, 0);
    chk("retry_we",    write_enable, 1);
    step();
    write_req = 1'b0;
    chk("retry_ptr",  write_ptr, 17);
    chk("retry_ack",  write_ack, 1);
    chk("retry_full", fifo_full, 1);

    // Pointer wrap from 31 to 0.
    read_ptr = 5'd16;
    do_writes(14);
    chk("pre_wrap_ptr", write_ptr, 31);
    read_ptr = 5'b11000;
    do_writes(1);
    chk("wrap_ptr",   write_ptr, 0);
    chk("wrap_full",  fifo_full, 0);
    chk("wrap_afull", fifo_afull, 0);

    // Flush together with write_req at write_ptr=7.
    do_writes(7);
    chk("pre_fl_ptr", write_ptr, 7);
    chk("pre_fl_ovf", overflow,  1);
    flush     = 1'b1;
    write_req = 1'b1;
    #1;
    chk("flwr_we", write_enable, 1);
    step();
    flush     = 1'b0;
    write_req = 1'b0;
    chk("flwr_ptr", write_ptr, 0);
    chk("flwr_ack", write_ack, 0);
    chk("flwr_ovf", overflow,  0);

    // Async reset mid-burst at write_ptr=9.
    read_ptr  = 5'd0;
    write_req = 1'b1;
    repeat (9) step();
    chk("burst_ptr", write_ptr, 9);
    chk("burst_ack", write_ack, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ptr",   write_ptr,  0);
    chk("arst_ack",   write_ack,  0);
    chk("arst_ovf",   overflow,   0);
    chk("arst_full",  fifo_full,  0);
    chk("arst_afull", fifo_afull, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_we",   write_enable, 1);
    chk("post_addr", write_ptr[3:0], 0);
    step();
    write_req = 1'b0;
    chk("post_ptr", write_ptr, 1);
    chk("post_ack", write_ack, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
